icache_refill_ctrl: RTL and testbench
=====================================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, fetch/memory address width.
REQ-002 SHALL have port clk_in  input  1  system clock; all state changes on rising edge only.
REQ-003 SHALL have port rst_in  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rdy_in  input  1  global ready; low freezes all state.
REQ-005 SHALL have port flush  input  1  abort current fetch (branch redirect).
REQ-006 SHALL have ports fetch_valid  input  1  and fetch_addr  input  ADDR_W: fetch request, word-aligned.
REQ-007 SHALL have ports fetch_done  output  1  (one-cycle pulse) and fetch_inst  output  32: returned instruction.
REQ-008 SHALL have ports cache_addr  output  ADDR_W, cache_hit  input  1, cache_rdata  input  32: combinational cache lookup.
REQ-009 SHALL have ports cache_update  output  1  (one-cycle pulse) and cache_wdata  output  32: refill write, at address cache_addr.
REQ-010 SHALL have ports mem_req  output  1, mem_gnt  input  1, mem_a  output  ADDR_W, mem_din  input  8: byte-wide memory; mem_din valid one cycle after mem_a issued under grant.

Function
REQ-011 SHALL implement states IDLE, REFILL, DONE.
REQ-012 IDLE: cache_addr = fetch_addr; base = {fetch_addr[ADDR_W-1:2],2'b00}.
REQ-013 IDLE, fetch_valid=1, cache_hit=1: next cycle fetch_done=1, fetch_inst=cache_rdata sampled at the request edge; stay IDLE; hit latency 1 cycle.
REQ-014 IDLE, fetch_valid=1, cache_hit=0: latch base, clear issue counter icnt and receive counter rcnt, enter REFILL.
REQ-015 REFILL: mem_req=1 while icnt<4; cache_addr = latched base.
REQ-016 Byte issue: mem_a = base+icnt; icnt increments only on cycles with mem_gnt=1 and icnt<4; grant loss pauses issue without losing progress.
REQ-017 Byte receive: on cycle after a granted issue, mem_din stored to bits [8*rcnt+7:8*rcnt] (little-endian), rcnt increments.
REQ-018 rcnt reaching 4 (after 4th byte captured): enter DONE.
REQ-019 DONE (one cycle): cache_update=1, cache_wdata=assembled word, fetch_done=1, fetch_inst=same word; next state IDLE.
REQ-020 Uncontended miss latency: 6 cycles from request edge to fetch_done (1 entry + 4 issue + 1 final receive, DONE output on 6th).
REQ-021 fetch_done and cache_update SHALL be low in all cycles not stated above; fetch_inst holds last value between pulses.
REQ-022 flush=1 (rdy_in=1): next state IDLE from any state; no fetch_done/cache_update that cycle or next; outstanding byte discarded; flush beats simultaneous fetch_valid.
REQ-023 fetch_valid ignored outside IDLE; new request in cycle after DONE accepted normally.
REQ-024 rdy_in=0: state, counters, assembled word, outputs frozen; a mem_din arriving while rdy_in=0 SHALL NOT be captured (memory is also paused by rdy_in).
REQ-025 Address arithmetic mod 2^ADDR_W; base at top of space wraps.

Reset
REQ-026 rst_in=0 at rising edge: state IDLE, icnt=rcnt=0, assembled word 0, fetch_done=0, fetch_inst=0, cache_update=0, cache_wdata=0, mem_req=0, mem_a=0.
REQ-027 Reset SHALL override rdy_in and flush; reset mid-REFILL abandons refill without cache write.

Verification
REQ-028 Hit: fetch_addr=0x1000, cache_hit=1, cache_rdata=0x00A00093 -> fetch_done one cycle later, fetch_inst=0x00A00093, mem_req stays 0.
REQ-029 Miss: fetch_addr=0x2004, mem_gnt=1, bytes 0x13,0x05,0x10,0x00 -> mem_a 0x2004..0x2007, cache_update and fetch_done together 6 cycles after request, word 0x00100513.
REQ-030 Grant stall: as REQ-029 with mem_gnt=0 for 3 cycles after 2nd byte -> same word, completion delayed exactly 3 cycles, no repeated addresses.
REQ-031 Flush mid-refill after 2 bytes -> IDLE next cycle, no cache_update, next request at 0x3000 starts fresh from mem_a=0x3000.
REQ-032 rdy_in low 4 cycles during REFILL -> all outputs frozen, completion delayed 4 cycles, word correct.
REQ-033 rst_in low during REFILL -> all outputs at reset values next cycle, no cache_update afterwards.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller.
// Serves hits in one cycle; on a miss it fetches the word byte-by-byte and writes it back.
module icache_refill_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  output logic [31:0]       fetch_inst,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic [31:0]       cache_rdata,
  output logic              cache_update,
  output logic [31:0]       cache_wdata,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_din
);

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        icnt_q, icnt_d;
  logic [2:0]        rcnt_q, rcnt_d;
  logic              pend_q, pend_d;
  logic [31:0]       word_q, word_d;
  logic              done_q, done_d;
  logic [31:0]       inst_q, inst_d;
  logic              upd_q, upd_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] fetch_base;

  assign fetch_base   = {fetch_addr[ADDR_W-1:2], 2'b00};
  assign mem_req      = (state_q == REFILL) && !icnt_q[2];
  assign mem_a        = base_q + {{(ADDR_W-3){1'b0}}, icnt_q};
  assign cache_addr   = (state_q == IDLE) ? fetch_addr : base_q;
  assign fetch_done   = done_q;
  assign fetch_inst   = inst_q;
  assign cache_update = upd_q;
  assign cache_wdata  = wdata_q;

  // Next-state: hit/miss dispatch, byte issue/receive, completion pulse.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    icnt_d  = icnt_q;
    rcnt_d  = rcnt_q;
    pend_d  = pend_q;
    word_d  = word_q;
    done_d  = done_q;
    inst_d  = inst_q;
    upd_d   = upd_q;
    wdata_d = wdata_q;
    if (rdy_in) begin
      done_d = 1'b0;
      upd_d  = 1'b0;
      if (flush) begin
        state_d = IDLE;
        pend_d  = 1'b0;
        icnt_d  = '0;
        rcnt_d  = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (fetch_valid) begin
              if (cache_hit) begin
                done_d = 1'b1;
                inst_d = cache_rdata;
              end else begin
                base_d  = fetch_base;
                icnt_d  = '0;
                rcnt_d  = '0;
                pend_d  = 1'b0;
                word_d  = '0;
                state_d = REFILL;
              end
            end
          end
          REFILL: begin
            pend_d = mem_req && mem_gnt;
            if (mem_req && mem_gnt) icnt_d = icnt_q + 3'd1;
            if (pend_q) begin
              word_d[{rcnt_q[1:0], 3'b000} +: 8] = mem_din;
              rcnt_d = rcnt_q + 3'd1;
              if (rcnt_q == 3'd3) begin
                state_d = DONE;
                done_d  = 1'b1;
                upd_d   = 1'b1;
                inst_d  = word_d;
                wdata_d = word_d;
              end
            end
          end
          DONE: state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State and registered outputs; reset wins over rdy_in and flush.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      base_q  <= '0;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
      word_q  <= '0;
      done_q  <= 1'b0;
      inst_q  <= '0;
      upd_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
      upd_q   <= upd_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scenario bench for icache_refill_ctrl.
// Byte memory model plus word/address scoreboards.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic [31:0] fetch_inst;
  logic [31:0] cache_addr;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        cache_update;
  logic [31:0] cache_wdata;
  logic        mem_req, mem_gnt;
  logic [31:0] mem_a;
  logic [7:0]  mem_din = 8'h00;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_word_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] issued[$];
  logic [7:0]  mem_tbl[logic [31:0]];

  always #5 clk = ~clk;

  icache_refill_ctrl #(.ADDR_W(32)) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_done  (fetch_done),
    .fetch_inst  (fetch_inst),
    .cache_addr  (cache_addr),
    .cache_hit   (cache_hit),
    .cache_rdata (cache_rdata),
    .cache_update(cache_update),
    .cache_wdata (cache_wdata),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_a       (mem_a),
    .mem_din     (mem_din)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: data appears one cycle after a granted, ready issue.
  always @(posedge clk) begin
    if (rst_in && rdy_in && mem_req && mem_gnt) begin
      mem_din <= mem_tbl.exists(mem_a) ? mem_tbl[mem_a] : 8'h00;
      issued.push_back(mem_a);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic wait_done(input int ga, input int gl,
                           input int ra, input int rl,
                           output int lat, output logic [31:0] inst,
                           output logic upd, output logic [31:0] wd,
                           output bit froze, output bit tout);
    int r;
    logic [97:0] snap;
    logic [97:0] now;
    tout  = 1'b1;
    upd   = 1'b0;
    froze = 1'b1;
    lat   = 0;
    inst  = '0;
    wd    = '0;
    snap  = '0;
    @(negedge clk);
    r = cyc;
    fetch_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      now = {mem_req, mem_a, cache_addr, fetch_done,
             cache_update, fetch_inst[31:0]};
      if (cache_update) begin
        upd = 1'b1;
        wd  = cache_wdata;
      end
      if (fetch_done) begin
        lat  = cyc - r + 1;
        inst = fetch_inst;
        tout = 1'b0;
        break;
      end
      if (k == ra) snap = now;
      if (rl > 0 && k > ra && k <= ra + rl && now !== snap)
        froze = 1'b0;
      mem_gnt = !(k >= ga && k < ga + gl);
      rdy_in  = !(k >= ra && k < ra + rl);
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    rdy_in  = 1'b1;
  endtask

  task automatic do_miss(input logic [31:0] addr, input logic [31:0] word,
                         input int ga, input int gl,
                         input int ra, input int rl,
                         output int lat, output logic [31:0] inst,
                         output logic upd, output logic [31:0] wd,
                         output bit froze, output bit tout);
    logic [31:0] b;
    b = {addr[31:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      mem_tbl[b + 32'(i)] = word[8*i +: 8];
      exp_addr_q.push_back(b + 32'(i));
    end
    exp_word_q.push_back(word);
    issued.delete();
    @(negedge clk);
    fetch_addr  = addr;
    cache_hit   = 1'b0;
    fetch_valid = 1'b1;
    wait_done(ga, gl, ra, rl, lat, inst, upd, wd, froze, tout);
  endtask

  task automatic test_reset;
    rst_in      = 1'b0;
    rdy_in      = 1'b1;
    flush       = 1'b1;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0000_0040;
    cache_hit   = 1'b1;
    cache_rdata = 32'hFFFF_FFFF;
    mem_gnt     = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (fetch_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_done got=%b want=0", fetch_done);
    end
    vectors++;
    if (fetch_inst !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_inst got=%h want=0", fetch_inst);
    end
    vectors++;
    if (cache_update !== 1'b0 || cache_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_upd got=%b/%h want=0/0", cache_update, cache_wdata);
    end
    vectors++;
    if (mem_req !== 1'b0 || mem_a !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mem got=%b/%h want=0/0", mem_req, mem_a);
    end
    vectors++;
    if (cache_addr !== 32'h0000_0040) begin
      miscompares++;
      $display("FAIL rst_caddr got=%h want=00000040", cache_addr);
    end
    rst_in      = 1'b1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    cache_hit   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hit;
    int lat;
    logic [31:0] inst, wd, w;
    logic upd;
    bit froze, tout;
    issued.delete();
    exp_word_q.push_back(32'h00A0_0093);
    fetch_addr  = 32'h0000_1000;
    cache_hit   = 1'b1;
    cache_rdata = 32'h00A0_0093;
    fetch_valid = 1'b1;
    wait_done(-1, 0, -1, 0, lat, inst, upd, wd, froze, tout);
    cache_hit   = 1'b0;
    cache_rdata = 32'h0;
    w = exp_word_q.pop_front();
    vectors++;
    if (tout || lat != 1) begin
      miscompares++;
      $display("FAIL hit_latency got=%0d tout=%0b want=1", lat, tout);
    end
    vectors++;
    if (inst !== w) begin
      miscompares++;
      $display("FAIL hit_inst got=%h want=%h", inst, w);
    end
    vectors++;
    if (upd !== 1'b0 || issued.size() != 0) begin
      miscompares++;
      $display("FAIL hit_nomem got upd=%b issues=%0d want 0/0", upd, issued.size());
    end
    @(negedge clk);
    vectors++;
    if (fetch_done !== 1'b0 || fetch_inst !== w) begin
      miscompares++;
      $display("FAIL hit_pulse got=%b/%h want=0/%h", fetch_done, fetch_inst, w);
    end
  endtask

  task automatic run_miss(input string nm, input logic [31:0] addr,
                          input logic [31:0] word, input int ga, input int gl,
                          input int ra, input int rl, input int want_lat);
    int lat;
    logic [31:0] inst, wd, w, a, got;
    logic upd;
    bit froze, tout;
    do_miss(addr, word, ga, gl, ra, rl, lat, inst, upd, wd, froze, tout);
    w = exp_word_q.pop_front();
    vectors++;
    if (tout || lat != want_lat) begin
      miscompares++;
      $display("FAIL %s_latency got=%0d tout=%0b want=%0d", nm, lat, tout, want_lat);
    end
    vectors++;
    if (inst !== w || wd !== w || upd !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_word got inst=%h wdata=%h upd=%b want=%h", nm, inst, wd, upd, w);
    end
    vectors++;
    if (!froze) begin
      miscompares++;
      $display("FAIL %s_frozen got=changed want=held", nm);
    end
    vectors++;
    if (issued.size() != 4) begin
      miscompares++;
      $display("FAIL %s_issue_count got=%0d want=4", nm, issued.size());
    end
    while (exp_addr_q.size() > 0) begin
      a   = exp_addr_q.pop_front();
      got = (issued.size() > 0) ? issued.pop_front() : 32'hxxxx_xxxx;
      vectors++;
      if (got !== a) begin
        miscompares++;
        $display("FAIL %s_mem_a got=%h want=%h", nm, got, a);
      end
    end
  endtask

  task automatic test_miss;
    run_miss("miss", 32'h0000_2004, 32'h0010_0513, -1, 0, -1, 0, 6);
  endtask

  task automatic test_grant_stall;
    run_miss("gstall", 32'h0000_2004, 32'h0010_0513, 2, 3, -1, 0, 9);
  endtask

  task automatic test_rdy_stall;
    run_miss("rstall", 32'h0000_2104, 32'hCAFE_F00D, -1, 0, 2, 4, 10);
  endtask

  task automatic test_wrap;
    run_miss("wrap", 32'hFFFF_FFFE, 32'hA5C3_3C5A, -1, 0, -1, 0, 6);
  endtask

  task automatic test_flush;
    int pulses;
    mem_tbl[32'h2000] = 8'hEF;
    mem_tbl[32'h2001] = 8'hBE;
    mem_tbl[32'h2002] = 8'hAD;
    mem_tbl[32'h2003] = 8'hDE;
    @(negedge clk);
    fetch_addr  = 32'h0000_2000;
    cache_hit   = 1'b0;
    fetch_valid = 1'b1;
    @(negedge clk);
    fetch_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || cache_addr !== 32'h0000_2000) begin
      miscompares++;
      $display("FAIL flush_idle got req=%b caddr=%h want=0/00002000", mem_req, cache_addr);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (fetch_done || cache_update) pulses++;
      @(negedge clk);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL flush_pulses got=%0d want=0", pulses);
    end
    fetch_addr  = 32'h0000_5000;
    fetch_valid = 1'b1;
    flush       = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    fetch_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || fetch_done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_beats_valid got req=%b done=%b want=0/0", mem_req, fetch_done);
    end
    run_miss("post_flush", 32'h0000_3000, 32'h1234_5678, -1, 0, -1, 0, 6);
  endtask

  task automatic test_back_to_back;
    logic [31:0] w;
    run_miss("b2b_miss", 32'h0000_6000, 32'h0041_0113, -1, 0, -1, 0, 6);
    fetch_addr  = 32'h0000_7000;
    cache_hit   = 1'b1;
    cache_rdata = 32'h1122_3344;
    fetch_valid = 1'b1;
    exp_word_q.push_back(32'h1122_3344);
    @(negedge clk);
    vectors++;
    if (fetch_done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ignored_in_done got=%b want=0", fetch_done);
    end
    @(negedge clk);
    fetch_valid = 1'b0;
    cache_hit   = 1'b0;
    w = exp_word_q.pop_front();
    vectors++;
    if (fetch_done !== 1'b1 || fetch_inst !== w) begin
      miscompares++;
      $display("FAIL b2b_hit got=%b/%h want=1/%h", fetch_done, fetch_inst, w);
    end
    @(negedge clk);
    vectors++;
    if (fetch_done !== 1'b0 || fetch_inst !== w) begin
      miscompares++;
      $display("FAIL b2b_hold got=%b/%h want=0/%h", fetch_done, fetch_inst, w);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    mem_tbl[32'h4000] = 8'h11;
    mem_tbl[32'h4001] = 8'h22;
    mem_tbl[32'h4002] = 8'h33;
    mem_tbl[32'h4003] = 8'h44;
    @(negedge clk);
    fetch_addr  = 32'h0000_4000;
    cache_hit   = 1'b0;
    fetch_valid = 1'b1;
    @(negedge clk);
    fetch_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
    vectors++;
    if (fetch_done !== 1'b0 || fetch_inst !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_fetch got=%b/%h want=0/0", fetch_done, fetch_inst);
    end
    vectors++;
    if (cache_update !== 1'b0 || cache_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_cache got=%b/%h want=0/0", cache_update, cache_wdata);
    end
    vectors++;
    if (mem_req !== 1'b0 || mem_a !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_mem got=%b/%h want=0/0", mem_req, mem_a);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (fetch_done || cache_update) pulses++;
      @(negedge clk);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL rmid_pulses got=%0d want=0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_grant_stall();
    test_rdy_stall();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
